// File: rtl/tlul_demux_1n_pkg.sv
// Shared TL-UL types and opcodes, the peripheral address table and the decode helper
// used by the 1:N demux and its error responder.
package tlul_demux_1n_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam int DEMUX_N_PERIPH = 11;

    // Devices 0..9 are 64 KiB windows; device 10 is a 16 MiB window overlapping them,
    // so it only wins where no lower-numbered device matches.
    localparam logic [DEMUX_N_PERIPH-1:0][31:0] ADDR_SPACE = {
        32'h4000_0000, 32'h4009_0000, 32'h4008_0000, 32'h4007_0000,
        32'h4006_0000, 32'h4005_0000, 32'h4004_0000, 32'h4003_0000,
        32'h4002_0000, 32'h4001_0000, 32'h4000_0000
    };

    localparam logic [DEMUX_N_PERIPH-1:0][31:0] ADDR_MASK = {
        32'h00FF_FFFF, {10{32'h0000_FFFF}}
    };

    function automatic logic addr_dec(input logic [31:0] addr,
                                      input logic [31:0] space,
                                      input logic [31:0] mask);
        return (addr & ~mask) == space;
    endfunction

endpackage

// File: rtl/tlul_demux_1n_err.sv
// tlul_err_resp: single-entry TL-UL error responder. Answers one request per slot with
// d_error set and ErrData one cycle after acceptance, holding the response until d_ready.
module tlul_err_resp
    import tlul_demux_1n_pkg::*;
#(
    parameter logic [31:0] ErrData = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  tl_a_op_e   a_opcode,
    input  logic [7:0] a_source,
    input  logic [1:0] a_size,
    input  logic       d_ready,
    output tl_d2h_t    rsp
);

    logic       err_pend;
    tl_a_op_e   err_opcode;
    logic [7:0] err_source;
    logic [1:0] err_size;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend <= 1'b0;
        end else if (err_pend) begin
            if (d_ready) err_pend <= 1'b0;
        end else if (a_valid) begin
            err_pend   <= 1'b1;
            err_opcode <= a_opcode;
            err_source <= a_source;
            err_size   <= a_size;
        end
    end

    always_comb begin
        rsp          = '0;
        rsp.a_ready  = ~err_pend;
        rsp.d_valid  = err_pend;
        rsp.d_opcode = (err_opcode == Get) ? AccessAckData : AccessAck;
        rsp.d_size   = err_size;
        rsp.d_source = err_source;
        rsp.d_data   = ErrData;
        rsp.d_error  = 1'b1;
    end

endmodule

// File: rtl/tlul_demux_1n.sv
// TL-UL 1:N demux: routes host requests to N devices by address, keeps responses in order
// by stalling target switches, and answers unmapped addresses. TLUL_DEMUX_ERR_LOG_EN adds an error log.
module tlul_demux_1n
    import tlul_demux_1n_pkg::*;
#(
    parameter int                   N              = DEMUX_N_PERIPH,
    parameter logic [N-1:0][31:0]   AddrSpace      = ADDR_SPACE,
    parameter logic [N-1:0][31:0]   AddrMask       = ADDR_MASK,
    parameter int                   MaxOutstanding = 4,
    parameter logic [31:0]          ErrData        = 32'hFFFF_FFFF
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o,
    output tl_h2d_t tl_d_o [N],
    input  tl_d2h_t tl_d_i [N]
`ifdef TLUL_DEMUX_ERR_LOG_EN
    ,
    input  logic        err_clr_i,
    output logic        err_valid_o,
    output logic [31:0] err_addr_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int CNT_W = $clog2(MaxOutstanding + 1);
    localparam int TGT_W = $clog2(N + 1);

    logic [CNT_W-1:0] out_cnt;
    logic [TGT_W-1:0] tgt;
    logic [TGT_W-1:0] sel;
    logic             stall, sel_ready, a_ready, a_acc, d_acc, d_en;
    logic             err_a_valid, err_d_ready;
    tl_d2h_t          err_rsp, rsp;

    // Lowest matching index wins; no match selects the error port N.
    always_comb begin
        sel = TGT_W'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (addr_dec(tl_h_i.a_address, AddrSpace[i], AddrMask[i])) sel = TGT_W'(i);
        end
    end

    always_comb begin
        stall = (out_cnt == CNT_W'(MaxOutstanding)) || (out_cnt != '0 && sel != tgt);
        sel_ready = err_rsp.a_ready;
        for (int i = 0; i < N; i++) begin
            if (sel == TGT_W'(i)) sel_ready = tl_d_i[i].a_ready;
        end
        a_ready     = ~rst_i & ~stall & sel_ready;
        a_acc       = tl_h_i.a_valid & a_ready;
        err_a_valid = tl_h_i.a_valid & ~rst_i & ~stall & (sel == TGT_W'(N));

        // Responses only pass while something is outstanding, so a stray d_valid cannot underflow.
        d_en = ~rst_i & (out_cnt != '0);
        rsp  = err_rsp;
        for (int i = 0; i < N; i++) begin
            if (tgt == TGT_W'(i)) rsp = tl_d_i[i];
        end
        tl_h_o         = rsp;
        tl_h_o.d_valid = rsp.d_valid & d_en;
        tl_h_o.a_ready = a_ready;
        d_acc          = tl_h_o.d_valid & tl_h_i.d_ready;
        err_d_ready    = tl_h_i.d_ready & d_en & (tgt == TGT_W'(N));

        for (int i = 0; i < N; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid & ~rst_i & ~stall & (sel == TGT_W'(i));
            tl_d_o[i].d_ready = tl_h_i.d_ready & d_en & (tgt == TGT_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt <= '0;
            tgt     <= '0;
        end else begin
            if (a_acc) tgt <= sel;
            case ({a_acc, d_acc})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    tlul_err_resp #(
        .ErrData (ErrData)
    ) u_err_resp (
        .clk      (clk_i),
        .rst      (rst_i),
        .a_valid  (err_a_valid),
        .a_opcode (tl_h_i.a_opcode),
        .a_source (tl_h_i.a_source),
        .a_size   (tl_h_i.a_size),
        .d_ready  (err_d_ready),
        .rsp      (err_rsp)
    );

`ifdef TLUL_DEMUX_ERR_LOG_EN
    logic err_acc;
    assign err_acc = a_acc & (sel == TGT_W'(N));

    // The first error address is kept until cleared; a clear coinciding with an error logs it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_cnt_o   <= '0;
        end else if (err_clr_i) begin
            err_valid_o <= err_acc;
            err_addr_o  <= err_acc ? tl_h_i.a_address : 32'h0;
            err_cnt_o   <= err_acc ? 16'h1 : 16'h0;
        end else if (err_acc) begin
            if (!err_valid_o) begin
                err_valid_o <= 1'b1;
                err_addr_o  <= tl_h_i.a_address;
            end
            if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_tlul_demux_1n.sv
// Directed bench for tlul_demux_1n: stimulus pushes expected host responses into a queue,
// a monitor pops and compares each D-channel handshake. Build with TLUL_DEMUX_ERR_LOG_EN to cover the log.
module tb_tlul_demux_1n;
    import tlul_demux_1n_pkg::*;

    localparam int N = DEMUX_N_PERIPH;
    localparam int W = 44;

    logic    clk = 1'b0;
    logic    rst_i;
    tl_h2d_t tl_h_i;
    tl_d2h_t tl_h_o;
    tl_h2d_t tl_d_o [N];
    tl_d2h_t tl_d_i [N];
`ifdef TLUL_DEMUX_ERR_LOG_EN
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [15:0] err_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int w;
    logic [W-1:0] mon_got, mon_exp;

    tlul_demux_1n dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i)
`ifdef TLUL_DEMUX_ERR_LOG_EN
        ,
        .err_clr_i   (err_clr),
        .err_valid_o (err_valid),
        .err_addr_o  (err_addr),
        .err_cnt_o   (err_cnt)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] dev_data(input int i);
        return 32'hD0D0_0000 | 32'(i);
    endfunction

    function automatic logic [W-1:0] rsp_exp(input tl_d_op_e op, input logic [7:0] src,
                                             input logic err, input logic [31:0] data);
        return {op, src, err, data};
    endfunction

    function automatic logic [15:0] avalid_vec();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = tl_d_o[i].a_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_i && tl_h_o.d_valid && tl_h_i.d_ready) begin
            n_tests++;
            mon_got = {tl_h_o.d_opcode, tl_h_o.d_source, tl_h_o.d_error, tl_h_o.d_data};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL d_rsp: unexpected response %0h", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL d_rsp: got %0h expected %0h", mon_got, mon_exp);
                end
            end
        end
    end

    // driver tasks (called just after a rising edge)
    task automatic drive_a(input tl_a_op_e op, input logic [31:0] addr, input logic [7:0] src);
        #1;
        tl_h_i.a_valid   = 1'b1;
        tl_h_i.a_opcode  = op;
        tl_h_i.a_address = addr;
        tl_h_i.a_source  = src;
        tl_h_i.a_size    = 2'd2;
        tl_h_i.a_mask    = 4'hF;
    endtask

    task automatic idle_a();
        #1;
        tl_h_i.a_valid = 1'b0;
    endtask

    // Waits for a_ready, checks routing at the accepting cycle, pushes the expected response.
    task automatic wait_accept(input string name, input logic [W-1:0] e,
                               input logic [15:0] exp_vec, output int waits);
        waits = 0;
        @(negedge clk);
        while (!tl_h_o.a_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!tl_h_o.a_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: a_ready timeout got 0 expected 1", name);
        end else begin
            chk({name, "_route"}, 64'(avalid_vec()), 64'(exp_vec));
            @(posedge clk);
            exp_q.push_back(e);
        end
    endtask

    task automatic dev_rsp(input int i, input logic [7:0] src);
        int n;
        n = 0;
        #1;
        tl_d_i[i].d_valid  = 1'b1;
        tl_d_i[i].d_source = src;
        @(negedge clk);
        while (!tl_d_o[i].d_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!tl_d_o[i].d_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL dev_rsp%0d: d_ready timeout got 0 expected 1", i);
        end
        @(posedge clk);
        #1;
        tl_d_i[i].d_valid = 1'b0;
    endtask

    task automatic single(input string name, input logic [31:0] addr, input logic [7:0] src,
                          input int dev);
        int wt;
        drive_a(Get, addr, src);
        if (dev < N)
            wait_accept(name, rsp_exp(AccessAckData, src, 1'b0, dev_data(dev)), 16'(1) << dev, wt);
        else
            wait_accept(name, rsp_exp(AccessAckData, src, 1'b1, 32'hFFFF_FFFF), 16'h0, wt);
        idle_a();
        if (dev < N) dev_rsp(dev, src);
        else repeat (2) @(posedge clk);
    endtask

    initial begin
        // reset with a live request on the host side
        rst_i  = 1'b1;
        tl_h_i = '0;
        tl_h_i.d_ready   = 1'b1;
        tl_h_i.a_valid   = 1'b1;
        tl_h_i.a_address = 32'h4002_0000;
        for (int i = 0; i < N; i++) begin
            tl_d_i[i]          = '0;
            tl_d_i[i].a_ready  = 1'b1;
            tl_d_i[i].d_opcode = AccessAckData;
            tl_d_i[i].d_size   = 2'd2;
            tl_d_i[i].d_data   = dev_data(i);
        end
`ifdef TLUL_DEMUX_ERR_LOG_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 64'(tl_h_o.a_ready), 64'd0);
        chk("rst_a_valid", 64'(avalid_vec()), 64'd0);
        chk("rst_d_valid", 64'(tl_h_o.d_valid), 64'd0);
        chk("rst_out_cnt", 64'(dut.out_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        tl_h_i.a_valid = 1'b0;
        @(posedge clk);

        // single Get to device 2
        drive_a(Get, 32'h4002_0000, 8'h11);
        wait_accept("t1", rsp_exp(AccessAckData, 8'h11, 1'b0, dev_data(2)), 16'h0004, w);
        chk("t1_wait", 64'(w), 64'd0);
        idle_a();
        @(negedge clk);
        chk("t1_cnt1", 64'(dut.out_cnt), 64'd1);
        @(posedge clk);
        dev_rsp(2, 8'h11);
        @(negedge clk);
        chk("t1_cnt0", 64'(dut.out_cnt), 64'd0);
        @(posedge clk);

        // target switch stalls while device 0 response is outstanding
        drive_a(Get, 32'h4000_0100, 8'h20);
        wait_accept("t2a", rsp_exp(AccessAckData, 8'h20, 1'b0, dev_data(0)), 16'h0001, w);
        drive_a(Get, 32'h4005_0000, 8'h21);
        @(negedge clk);
        chk("t2_stall_ready", 64'(tl_h_o.a_ready), 64'd0);
        chk("t2_stall_valid", 64'(tl_d_o[5].a_valid), 64'd0);
        @(posedge clk);
        dev_rsp(0, 8'h20);
        wait_accept("t2b", rsp_exp(AccessAckData, 8'h21, 1'b0, dev_data(5)), 16'h0020, w);
        chk("t2_release_wait", 64'(w), 64'd0);
        idle_a();
        dev_rsp(5, 8'h21);

        // outstanding limit
        @(posedge clk);
        for (int s = 0; s < 4; s++) begin
            drive_a(Get, 32'h4001_0040, 8'(s));
            wait_accept("t3", rsp_exp(AccessAckData, 8'(s), 1'b0, dev_data(1)), 16'h0002, w);
        end
        drive_a(Get, 32'h4001_0040, 8'd4);
        @(negedge clk);
        chk("t3_max_ready", 64'(tl_h_o.a_ready), 64'd0);
        chk("t3_max_cnt", 64'(dut.out_cnt), 64'd4);
        @(posedge clk);
        dev_rsp(1, 8'd0);
        wait_accept("t3_5th", rsp_exp(AccessAckData, 8'd4, 1'b0, dev_data(1)), 16'h0002, w);
        chk("t3_release_wait", 64'(w), 64'd0);
        idle_a();
        for (int s = 1; s < 5; s++) dev_rsp(1, 8'(s));

        // decode error responder, then back-to-back error with one bubble
        @(posedge clk);
        drive_a(Get, 32'hDEAD_0000, 8'd3);
        wait_accept("t4_get", rsp_exp(AccessAckData, 8'd3, 1'b1, 32'hFFFF_FFFF), 16'h0, w);
        drive_a(PutFullData, 32'hDEAD_0004, 8'd7);
        @(negedge clk);
        chk("t4_next_d_valid", 64'(tl_h_o.d_valid), 64'd1);
        chk("t4_d_error", 64'(tl_h_o.d_error), 64'd1);
        wait_accept("t4_put", rsp_exp(AccessAck, 8'd7, 1'b1, 32'hFFFF_FFFF), 16'h0, w);
        chk("t4_bubble", 64'(w), 64'd0);
        idle_a();
        repeat (2) @(posedge clk);

        // decode priority and window boundaries
        single("dec_dev0", 32'h4000_0010, 8'h30, 0);
        single("dec_dev9_top", 32'h4009_FFFC, 8'h31, 9);
        single("dec_dev10_low", 32'h400A_0000, 8'h32, 10);
        single("dec_dev10_high", 32'h40F0_1234, 8'h33, 10);
        single("dec_unmapped", 32'h4100_0000, 8'h34, N);

        // simultaneous A and D accept leaves the count unchanged
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            drive_a(Get, 32'h4003_0000, 8'(8'h40 + s));
            wait_accept("t5", rsp_exp(AccessAckData, 8'(8'h40 + s), 1'b0, dev_data(3)), 16'h0008, w);
        end
        drive_a(Get, 32'h4003_0000, 8'h42);
        tl_d_i[3].d_valid  = 1'b1;
        tl_d_i[3].d_source = 8'h40;
        wait_accept("t5_both", rsp_exp(AccessAckData, 8'h42, 1'b0, dev_data(3)), 16'h0008, w);
        #1;
        tl_d_i[3].d_valid = 1'b0;
        tl_h_i.a_valid    = 1'b0;
        @(negedge clk);
        chk("t5_cnt_same", 64'(dut.out_cnt), 64'd2);

        // reset mid-transaction with three outstanding
        @(posedge clk);
        drive_a(Get, 32'h4003_0000, 8'h43);
        wait_accept("t5_third", rsp_exp(AccessAckData, 8'h43, 1'b0, dev_data(3)), 16'h0008, w);
        #1;
        rst_i = 1'b1;
        tl_d_i[3].d_valid = 1'b1;
        @(negedge clk);
        chk("t5_cnt3", 64'(dut.out_cnt), 64'd3);
        chk("t5_rst_a_ready", 64'(tl_h_o.a_ready), 64'd0);
        chk("t5_rst_d_valid", 64'(tl_h_o.d_valid), 64'd0);
        chk("t5_rst_a_valid", 64'(avalid_vec()), 64'd0);
        @(negedge clk);
        chk("t5_rst_cnt", 64'(dut.out_cnt), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i             = 1'b0;
        tl_h_i.a_valid    = 1'b0;
        tl_d_i[3].d_valid = 1'b0;
        @(posedge clk);

`ifdef TLUL_DEMUX_ERR_LOG_EN
        @(negedge clk);
        chk("log_rst_valid", 64'(err_valid), 64'd0);
        @(posedge clk);
        single("log_e1", 32'h1000_0000, 8'h50, N);
        single("log_e2", 32'h2000_0000, 8'h51, N);
        @(negedge clk);
        chk("log_valid", 64'(err_valid), 64'd1);
        chk("log_addr", 64'(err_addr), 64'h1000_0000);
        chk("log_cnt", 64'(err_cnt), 64'd2);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("log_clr_valid", 64'(err_valid), 64'd0);
        chk("log_clr_addr", 64'(err_addr), 64'd0);
        chk("log_clr_cnt", 64'(err_cnt), 64'd0);
`endif

        // final report
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
